mmu_8722_regs: RTL and testbench
================================

# mmu_8722_regs

Register file and sequencer for the C128 memory-management configuration that drives the banking PLA. It holds the configuration register (CR), four preconfiguration registers (PCRA–PCRD), mode, RAM and page-pointer registers, and the version register. It decodes CPU accesses in the $D500–$D50B and $FF00–$FF04 windows and presents registered configuration outputs (ms0–ms3, z80en, c128 mode, RAM bank, page pointers) to the PLA and address translation logic. All state changes happen on one clock edge. Outputs never glitch mid-cycle.

## Interface
- ID_VERSION, 8'h20: value returned by VR reads.
- P1_RESET, 16'h0001: reset value of page pointer P1.
- clk  in  1  system clock; all registers on rising edge
- rst  in  1  asynchronous, active-high reset
- cs_io  in  1  $D500–$D50F decode qualified by I/O visible
- cs_ff  in  1  $FF00–$FF04 decode (always visible)
- addr  in  4  CPU address bits 3:0
- rd_stb  in  1  one-cycle read strobe
- wr_stb  in  1  one-cycle write strobe
- din  in  8  write data
- dout  out  8  registered read data
- dout_en  out  1  dout valid (drives bus); high one cycle after accepted read
- cr  out  8  current configuration register
- ms  out  4  {ms3,ms2,ms1,ms0} = {CR[5:4],CR[3:2]} high/mid ROM select to PLA
- io_sel  out  1  !CR[0] (I/O visible at $D000)
- z80en  out  1  !MCR[0] (Z80 active)
- c64_mode  out  1  MCR[6]
- ram_bank  out  2  CR[7:6]
- rcr  out  8  RAM config (shared size/common area)
- p0, p1  out  16  committed page pointers {PxH,PxL}
- cfg_chg  out  1  one-cycle pulse when cr changes value

## Operation
- Register map: when cs_io is high, indexes 0 to 11 select CR, PCRA–PCRD, MCR, RCR, P0L, P0H, P1L, P1H and VR. Indexes 12 to 15 read 8'hFF and ignore writes. When cs_ff is high, index 0 selects CR and indexes 1 to 4 perform LCRA–LCRD.
- If cs_io and cs_ff are both high, cs_ff wins.
- CR write at $D500 or $FF00 loads din.
- LCRx write at $FF01–$FF04 loads CR from PCRx and ignores din.
- LCRx read returns PCRx and does not change CR.
- Page pointer writes:
  - A PxH write stores din in a holding register hold_x only.
  - A PxL write commits px = {hold_x, din} atomically.
  - A PxH read returns the committed high byte, not hold_x.
- MCR:
  - Bits 3 and 2 are read-only. They read as 1.
  - Bits 7, 6, 5, 4, 1 and 0 are writable.
  - MCR write with din[0]=1 switches z80en low on the next edge.
- VR is read-only. Writes to VR are ignored.
- cfg_chg asserts for one cycle whenever the newly loaded CR differs from the previous value. This applies to both direct writes and LCR loads.
- Simultaneous rd_stb and wr_stb: the write is performed and the read is ignored. dout_en stays low.
- Reset values:
  - CR=8'h00, PCRA–PCRD=8'h00, MCR=8'h00 (Z80 active), RCR=8'h00
  - P0=16'h0000, P1=P1_RESET, hold_0=8'h00, hold_1=8'h00
  - dout=8'h00, dout_en=0, cfg_chg=0
- Asserting rst mid-access aborts the access. No partial page-pointer commit survives.

## Timing
- Writes take effect on the clk edge where wr_stb is high. Derived outputs (ms, z80en, etc.) update on that same edge with zero added latency; they are decoded from registers.
- Read latency is 1 cycle: dout and dout_en are valid in the cycle after rd_stb. dout_en stays high for exactly 1 cycle.
- cfg_chg is high in the cycle after the CR-changing edge.
- Back-to-back writes are accepted every cycle. A PxH write followed immediately by a PxL write commits the new high byte.
- Writing PxL without a preceding PxH write reuses the last hold_x value, which is the reset value if no PxH write has occurred.

## Structure
- Package mmu_pkg holds:
  - register index localparams (IDX_CR … IDX_VR)
  - MCR read-only mask 8'h0C
  - reset value constants
  - a function decoding the CR bit fields
- One sub-module, mmu_page_ptr, is instantiated twice (P0 and P1). It contains the hold register, the commit-on-low-write logic and the committed 16-bit output.
- The top level contains the address decode, CR/PCR/MCR/RCR registers, read mux and cfg_chg compare.

## Test plan
- Reset, then read all 12 I/O indexes -> expect CR=00, PCRs=00, MCR=0C, RCR=00, P0L=00, P0H=00, P1L=01, P1H=00, VR=20; z80en=1.
- Write PCRB=8'h3E, then write $FF02 with din=8'hAA -> CR=3E, ms=4'hF, io_sel=1, cfg_chg pulses 1 cycle; repeat -> no pulse.
- Write P0H=12 -> p0 stays 0000 and P0H reads 00. Then write P0L=34 -> p0=1234 on that edge.
- Write MCR=8'hF1 -> MCR reads F1|0C=FD, z80en=0, c64_mode=1.
- Assert cs_io and cs_ff together with addr=0 and write din=55 -> CR=55. Issue simultaneous rd_stb+wr_stb -> write applied, dout_en stays 0.
- Write P1H=7F, assert rst before the P1L write, release, then write P1L=00 -> p1=0000, i.e. hold was cleared by reset.

Source files
------------

// File: rtl/mmu_8722_regs_pkg.sv
// Shared constants, register indexes and CR field decoding for the C128 MMU register block.
package mmu_pkg;

    // Version register contents and page-pointer reset values
    localparam logic [7:0]  ID_VERSION    = 8'h20;
    localparam logic [15:0] P0_RESET      = 16'h0000;
    localparam logic [15:0] P1_RESET      = 16'h0001;
    localparam logic [7:0]  HOLD_RESET    = 8'h00;

    // Reset values of the configuration registers
    localparam logic [7:0]  CR_RESET      = 8'h00;
    localparam logic [7:0]  PCR_RESET     = 8'h00;
    localparam logic [7:0]  MCR_RESET     = 8'h00;
    localparam logic [7:0]  RCR_RESET     = 8'h00;
    localparam logic [7:0]  DOUT_RESET    = 8'h00;

    // MCR bits 3:2 are not stored and always read back as 1
    localparam logic [7:0]  MCR_RO_MASK   = 8'h0C;

    // Value returned for the unused I/O indexes 12..15
    localparam logic [7:0]  UNMAPPED_READ = 8'hFF;

    // I/O window register indexes ($D500 + idx)
    localparam logic [3:0]  IDX_CR   = 4'd0;
    localparam logic [3:0]  IDX_PCRA = 4'd1;
    localparam logic [3:0]  IDX_PCRB = 4'd2;
    localparam logic [3:0]  IDX_PCRC = 4'd3;
    localparam logic [3:0]  IDX_PCRD = 4'd4;
    localparam logic [3:0]  IDX_MCR  = 4'd5;
    localparam logic [3:0]  IDX_RCR  = 4'd6;
    localparam logic [3:0]  IDX_P0L  = 4'd7;
    localparam logic [3:0]  IDX_P0H  = 4'd8;
    localparam logic [3:0]  IDX_P1L  = 4'd9;
    localparam logic [3:0]  IDX_P1H  = 4'd10;
    localparam logic [3:0]  IDX_VR   = 4'd11;

    // $FF00 window indexes
    localparam logic [3:0]  FF_CR    = 4'd0;
    localparam logic [3:0]  FF_LCRA  = 4'd1;
    localparam logic [3:0]  FF_LCRB  = 4'd2;
    localparam logic [3:0]  FF_LCRC  = 4'd3;
    localparam logic [3:0]  FF_LCRD  = 4'd4;

    typedef struct packed {
        logic [1:0] ram_bank;
        logic [3:0] ms;
        logic       io_sel;
    } cr_fields_t;

    // Split CR into the fields the PLA and address translation consume
    function automatic cr_fields_t decode_cr(input logic [7:0] cr_val);
        cr_fields_t f;
        f.ram_bank = cr_val[7:6];
        f.ms       = {cr_val[5:4], cr_val[3:2]};
        f.io_sel   = ~cr_val[0];
        return f;
    endfunction

endpackage

// File: rtl/mmu_8722_regs_page_ptr.sv
// One page pointer: high byte is staged in a hold register and the full
// 16-bit pointer is committed only when the low byte is written.
module mmu_page_ptr
    import mmu_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [7:0]  din,
    output logic [15:0] ptr
);

    logic [7:0]  hold_r;
    logic [15:0] ptr_r;

    // Stage the high byte; it is not visible until the low byte commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= HOLD_RESET;
        end else if (wr_hi) begin
            hold_r <= din;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Commit {hold, low} in a single edge so the pointer never shows a mixed value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= RESET_VAL;
        end else if (wr_lo) begin
            ptr_r <= {hold_r, din};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/mmu_8722_regs.sv
// C128 MMU register file: address decode, CR/PCR/MCR/RCR storage,
// registered read port and configuration-change pulse.
module mmu_8722_regs
    import mmu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_io,
    input  logic        cs_ff,
    input  logic [3:0]  addr,
    input  logic        rd_stb,
    input  logic        wr_stb,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_en,
    output logic [7:0]  cr,
    output logic [3:0]  ms,
    output logic        io_sel,
    output logic        z80en,
    output logic        c64_mode,
    output logic [1:0]  ram_bank,
    output logic [7:0]  rcr,
    output logic [15:0] p0,
    output logic [15:0] p1,
    output logic        cfg_chg
);

    logic [7:0]       cr_r;
    logic [3:0][7:0]  pcr_r;
    logic [7:0]       mcr_r;
    logic [7:0]       rcr_r;
    logic [7:0]       dout_r;
    logic             dout_en_r;
    logic             cfg_chg_r;

    logic             hit_s;
    logic             wr_cr_s;
    logic [7:0]       cr_wdata_s;
    logic [3:0]       wr_pcr_s;
    logic             wr_mcr_s;
    logic             wr_rcr_s;
    logic             wr_p0l_s;
    logic             wr_p0h_s;
    logic             wr_p1l_s;
    logic             wr_p1h_s;
    logic [7:0]       rd_data_s;
    logic             rd_acc_s;
    logic [15:0]      p0_s;
    logic [15:0]      p1_s;
    cr_fields_t       cr_f_s;

    // Decode the access: $FF00 window has priority over the $D500 window
    always_comb begin
        hit_s      = 1'b0;
        wr_cr_s    = 1'b0;
        cr_wdata_s = din;
        wr_pcr_s   = 4'b0000;
        wr_mcr_s   = 1'b0;
        wr_rcr_s   = 1'b0;
        wr_p0l_s   = 1'b0;
        wr_p0h_s   = 1'b0;
        wr_p1l_s   = 1'b0;
        wr_p1h_s   = 1'b0;
        rd_data_s  = UNMAPPED_READ;
        if (cs_ff) begin
            case (addr)
                FF_CR: begin
                    hit_s     = 1'b1;
                    wr_cr_s   = wr_stb;
                    rd_data_s = cr_r;
                end
                FF_LCRA: begin
                    hit_s      = 1'b1;
                    wr_cr_s    = wr_stb;
                    cr_wdata_s = pcr_r[0];
                    rd_data_s  = pcr_r[0];
                end
                FF_LCRB: begin
                    hit_s      = 1'b1;
                    wr_cr_s    = wr_stb;
                    cr_wdata_s = pcr_r[1];
                    rd_data_s  = pcr_r[1];
                end
                FF_LCRC: begin
                    hit_s      = 1'b1;
                    wr_cr_s    = wr_stb;
                    cr_wdata_s = pcr_r[2];
                    rd_data_s  = pcr_r[2];
                end
                FF_LCRD: begin
                    hit_s      = 1'b1;
                    wr_cr_s    = wr_stb;
                    cr_wdata_s = pcr_r[3];
                    rd_data_s  = pcr_r[3];
                end
                default: begin
                    hit_s = 1'b0;
                end
            endcase
        end else if (cs_io) begin
            hit_s = 1'b1;
            case (addr)
                IDX_CR:   begin wr_cr_s     = wr_stb; rd_data_s = cr_r;     end
                IDX_PCRA: begin wr_pcr_s[0] = wr_stb; rd_data_s = pcr_r[0]; end
                IDX_PCRB: begin wr_pcr_s[1] = wr_stb; rd_data_s = pcr_r[1]; end
                IDX_PCRC: begin wr_pcr_s[2] = wr_stb; rd_data_s = pcr_r[2]; end
                IDX_PCRD: begin wr_pcr_s[3] = wr_stb; rd_data_s = pcr_r[3]; end
                IDX_MCR:  begin wr_mcr_s    = wr_stb; rd_data_s = mcr_r | MCR_RO_MASK; end
                IDX_RCR:  begin wr_rcr_s    = wr_stb; rd_data_s = rcr_r;    end
                IDX_P0L:  begin wr_p0l_s    = wr_stb; rd_data_s = p0_s[7:0];  end
                IDX_P0H:  begin wr_p0h_s    = wr_stb; rd_data_s = p0_s[15:8]; end
                IDX_P1L:  begin wr_p1l_s    = wr_stb; rd_data_s = p1_s[7:0];  end
                IDX_P1H:  begin wr_p1h_s    = wr_stb; rd_data_s = p1_s[15:8]; end
                IDX_VR:   begin rd_data_s   = ID_VERSION; end
                default:  begin rd_data_s   = UNMAPPED_READ; end
            endcase
        end else begin
            hit_s = 1'b0;
        end
    end

    // A read is only accepted when no write shares the cycle
    assign rd_acc_s = hit_s & rd_stb & ~wr_stb;

    // CR load and change detection; the pulse lands in the cycle after the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr_r      <= CR_RESET;
            cfg_chg_r <= 1'b0;
        end else if (wr_cr_s) begin
            cr_r      <= cr_wdata_s;
            cfg_chg_r <= (cr_wdata_s != cr_r);
        end else begin
            cr_r      <= cr_r;
            cfg_chg_r <= 1'b0;
        end
    end

    // Preconfiguration, mode and RAM configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcr_r <= {4{PCR_RESET}};
            mcr_r <= MCR_RESET;
            rcr_r <= RCR_RESET;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_pcr_s[k]) begin
                    pcr_r[k] <= din;
                end else begin
                    pcr_r[k] <= pcr_r[k];
                end
            end
            if (wr_mcr_s) begin
                mcr_r <= din & ~MCR_RO_MASK;
            end else begin
                mcr_r <= mcr_r;
            end
            if (wr_rcr_s) begin
                rcr_r <= din;
            end else begin
                rcr_r <= rcr_r;
            end
        end
    end

    // Registered read port: data and valid one cycle after the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r    <= DOUT_RESET;
            dout_en_r <= 1'b0;
        end else if (rd_acc_s) begin
            dout_r    <= rd_data_s;
            dout_en_r <= 1'b1;
        end else begin
            dout_r    <= dout_r;
            dout_en_r <= 1'b0;
        end
    end

    mmu_page_ptr #(.RESET_VAL(P0_RESET)) u_p0 (
        .clk   (clk),
        .rst   (rst),
        .wr_hi (wr_p0h_s),
        .wr_lo (wr_p0l_s),
        .din   (din),
        .ptr   (p0_s)
    );

    mmu_page_ptr #(.RESET_VAL(P1_RESET)) u_p1 (
        .clk   (clk),
        .rst   (rst),
        .wr_hi (wr_p1h_s),
        .wr_lo (wr_p1l_s),
        .din   (din),
        .ptr   (p1_s)
    );

    assign cr_f_s   = decode_cr(cr_r);
    assign cr       = cr_r;
    assign ms       = cr_f_s.ms;
    assign io_sel   = cr_f_s.io_sel;
    assign ram_bank = cr_f_s.ram_bank;
    assign z80en    = ~mcr_r[0];
    assign c64_mode = mcr_r[6];
    assign rcr      = rcr_r;
    assign p0       = p0_s;
    assign p1       = p1_s;
    assign dout     = dout_r;
    assign dout_en  = dout_en_r;
    assign cfg_chg  = cfg_chg_r;

endmodule

// File: tb/tb_mmu_8722_regs.sv
// Directed, table-driven bench for the C128 MMU register block.
module tb_mmu_8722_regs;

    logic        clk;
    logic        rst;
    logic        cs_io;
    logic        cs_ff;
    logic [3:0]  addr;
    logic        rd_stb;
    logic        wr_stb;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_en;
    logic [7:0]  cr;
    logic [3:0]  ms;
    logic        io_sel;
    logic        z80en;
    logic        c64_mode;
    logic [1:0]  ram_bank;
    logic [7:0]  rcr;
    logic [15:0] p0;
    logic [15:0] p1;
    logic        cfg_chg;

    int checks;
    int failures;

    mmu_8722_regs dut (
        .clk      (clk),
        .rst      (rst),
        .cs_io    (cs_io),
        .cs_ff    (cs_ff),
        .addr     (addr),
        .rd_stb   (rd_stb),
        .wr_stb   (wr_stb),
        .din      (din),
        .dout     (dout),
        .dout_en  (dout_en),
        .cr       (cr),
        .ms       (ms),
        .io_sel   (io_sel),
        .z80en    (z80en),
        .c64_mode (c64_mode),
        .ram_bank (ram_bank),
        .rcr      (rcr),
        .p0       (p0),
        .p1       (p1),
        .cfg_chg  (cfg_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       ci;
        bit       cf;
        bit [3:0] a;
        bit       r;
        bit       w;
        bit [7:0] d;
        bit       en;
        bit [7:0] dout;
        bit [7:0] cr;
    } vec_t;

    vec_t vt[30];

    function automatic vec_t mk(input bit ci, input bit cf, input bit [3:0] a,
                                input bit r, input bit w, input bit [7:0] d,
                                input bit en, input bit [7:0] dv, input bit [7:0] c);
        vec_t v;
        v.ci = ci; v.cf = cf; v.a = a; v.r = r; v.w = w; v.d = d;
        v.en = en; v.dout = dv; v.cr = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One-cycle access: drive at negedge, sample 1 time unit after the edge
    task automatic acc(input bit ci, input bit cf, input bit [3:0] a,
                       input bit r, input bit w, input bit [7:0] d);
        @(negedge clk);
        cs_io = ci; cs_ff = cf; addr = a; rd_stb = r; wr_stb = w; din = d;
        @(posedge clk);
        #1;
        cs_io = 1'b0; cs_ff = 1'b0; rd_stb = 1'b0; wr_stb = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cs_io = 1'b0; cs_ff = 1'b0; addr = 4'd0; rd_stb = 1'b0; wr_stb = 1'b0; din = 8'h00;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vt[0]  = mk(1, 0, 4'd0,  1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[1]  = mk(1, 0, 4'd1,  1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[2]  = mk(1, 0, 4'd2,  1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[3]  = mk(1, 0, 4'd3,  1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[4]  = mk(1, 0, 4'd4,  1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[5]  = mk(1, 0, 4'd5,  1, 0, 8'h00, 1, 8'h0C, 8'h00);
        vt[6]  = mk(1, 0, 4'd6,  1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[7]  = mk(1, 0, 4'd7,  1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[8]  = mk(1, 0, 4'd8,  1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[9]  = mk(1, 0, 4'd9,  1, 0, 8'h00, 1, 8'h01, 8'h00);
        vt[10] = mk(1, 0, 4'd10, 1, 0, 8'h00, 1, 8'h00, 8'h00);
        vt[11] = mk(1, 0, 4'd11, 1, 0, 8'h00, 1, 8'h20, 8'h00);
        vt[12] = mk(1, 0, 4'd13, 1, 0, 8'h00, 1, 8'hFF, 8'h00);
        vt[13] = mk(1, 0, 4'd13, 0, 1, 8'h77, 0, 8'h00, 8'h00);
        vt[14] = mk(1, 0, 4'd11, 0, 1, 8'h99, 0, 8'h00, 8'h00);
        vt[15] = mk(1, 0, 4'd11, 1, 0, 8'h00, 1, 8'h20, 8'h00);
        vt[16] = mk(1, 0, 4'd2,  0, 1, 8'h3E, 0, 8'h00, 8'h00);
        vt[17] = mk(0, 1, 4'd2,  0, 1, 8'hAA, 0, 8'h00, 8'h3E);
        vt[18] = mk(0, 1, 4'd2,  1, 0, 8'h00, 1, 8'h3E, 8'h3E);
        vt[19] = mk(1, 0, 4'd6,  0, 1, 8'h5A, 0, 8'h00, 8'h3E);
        vt[20] = mk(1, 0, 4'd6,  1, 0, 8'h00, 1, 8'h5A, 8'h3E);
        vt[21] = mk(1, 0, 4'd1,  0, 1, 8'h81, 0, 8'h00, 8'h3E);
        vt[22] = mk(0, 1, 4'd1,  1, 0, 8'h00, 1, 8'h81, 8'h3E);
        vt[23] = mk(0, 1, 4'd0,  1, 0, 8'h00, 1, 8'h3E, 8'h3E);
        vt[24] = mk(0, 1, 4'd0,  0, 1, 8'hC3, 0, 8'h00, 8'hC3);
        vt[25] = mk(1, 0, 4'd0,  1, 0, 8'h00, 1, 8'hC3, 8'hC3);
        vt[26] = mk(0, 0, 4'd0,  1, 0, 8'h00, 0, 8'h00, 8'hC3);
        vt[27] = mk(1, 1, 4'd7,  0, 1, 8'h11, 0, 8'h00, 8'hC3);
        vt[28] = mk(1, 0, 4'd6,  1, 0, 8'h00, 1, 8'h5A, 8'hC3);
        vt[29] = mk(1, 0, 4'd7,  1, 0, 8'h00, 1, 8'h00, 8'hC3);

        // Reset state
        do_reset();
        chk("rst_dout",    {8'h00, dout},      16'h0000);
        chk("rst_dout_en", {15'h0, dout_en},   16'h0000);
        chk("rst_cfg_chg", {15'h0, cfg_chg},   16'h0000);
        chk("rst_cr",      {8'h00, cr},        16'h0000);
        chk("rst_ms",      {12'h0, ms},        16'h0000);
        chk("rst_io_sel",  {15'h0, io_sel},    16'h0001);
        chk("rst_z80en",   {15'h0, z80en},     16'h0001);
        chk("rst_c64",     {15'h0, c64_mode},  16'h0000);
        chk("rst_rcr",     {8'h00, rcr},       16'h0000);
        chk("rst_p0",      p0,                 16'h0000);
        chk("rst_p1",      p1,                 16'h0001);

        // Table-driven vectors
        for (int i = 0; i < 30; i++) begin
            acc(vt[i].ci, vt[i].cf, vt[i].a, vt[i].r, vt[i].w, vt[i].d);
            chk($sformatf("vec%0d_dout_en", i), {15'h0, dout_en}, {15'h0, vt[i].en});
            if (vt[i].en) begin
                chk($sformatf("vec%0d_dout", i), {8'h00, dout}, {8'h00, vt[i].dout});
            end
            chk($sformatf("vec%0d_cr", i), {8'h00, cr}, {8'h00, vt[i].cr});
        end
        idle();
        chk("tbl_dout_en_drop", {15'h0, dout_en}, 16'h0000);
        chk("tbl_rcr", {8'h00, rcr}, 16'h005A);

        // LCRB load, derived outputs and cfg_chg pulse
        do_reset();
        acc(1, 0, 4'd2, 0, 1, 8'h3E);
        chk("lcr_pcrb_no_chg", {15'h0, cfg_chg}, 16'h0000);
        acc(0, 1, 4'd2, 0, 1, 8'hAA);
        chk("lcr_cr",       {8'h00, cr},      16'h003E);
        chk("lcr_ms",       {12'h0, ms},      16'h000F);
        chk("lcr_io_sel",   {15'h0, io_sel},  16'h0001);
        chk("lcr_ram_bank", {14'h0, ram_bank},16'h0000);
        chk("lcr_cfg_chg",  {15'h0, cfg_chg}, 16'h0001);
        idle();
        chk("lcr_cfg_chg_drop", {15'h0, cfg_chg}, 16'h0000);
        acc(0, 1, 4'd2, 0, 1, 8'h00);
        chk("lcr_repeat_no_chg", {15'h0, cfg_chg}, 16'h0000);
        chk("lcr_repeat_cr",     {8'h00, cr},      16'h003E);

        // Page pointer hold and commit
        do_reset();
        acc(1, 0, 4'd8, 0, 1, 8'h12);
        chk("p0h_no_commit", p0, 16'h0000);
        acc(1, 0, 4'd8, 1, 0, 8'h00);
        chk("p0h_read_committed", {8'h00, dout}, 16'h0000);
        acc(1, 0, 4'd7, 0, 1, 8'h34);
        chk("p0_commit", p0, 16'h1234);
        acc(1, 0, 4'd8, 1, 0, 8'h00);
        chk("p0h_read", {8'h00, dout}, 16'h0012);
        acc(1, 0, 4'd7, 1, 0, 8'h00);
        chk("p0l_read", {8'h00, dout}, 16'h0034);

        // MCR writable/read-only bits
        do_reset();
        acc(1, 0, 4'd5, 0, 1, 8'hF1);
        chk("mcr_z80en", {15'h0, z80en},    16'h0000);
        chk("mcr_c64",   {15'h0, c64_mode}, 16'h0001);
        acc(1, 0, 4'd5, 1, 0, 8'h00);
        chk("mcr_read",  {8'h00, dout},     16'h00FD);
        acc(1, 0, 4'd5, 0, 1, 8'h02);
        acc(1, 0, 4'd5, 1, 0, 8'h00);
        chk("mcr_read2", {8'h00, dout},     16'h000E);
        chk("mcr_z80en2",{15'h0, z80en},    16'h0001);

        // Both windows selected, and simultaneous read/write
        do_reset();
        acc(1, 1, 4'd0, 0, 1, 8'h55);
        chk("both_cr",       {8'h00, cr},       16'h0055);
        chk("both_ms",       {12'h0, ms},       16'h0005);
        chk("both_io_sel",   {15'h0, io_sel},   16'h0000);
        chk("both_ram_bank", {14'h0, ram_bank}, 16'h0001);
        chk("both_cfg_chg",  {15'h0, cfg_chg},  16'h0001);
        acc(1, 0, 4'd0, 1, 1, 8'h66);
        chk("rdwr_cr",      {8'h00, cr},      16'h0066);
        chk("rdwr_dout_en", {15'h0, dout_en}, 16'h0000);
        idle();
        chk("rdwr_dout_en2", {15'h0, dout_en}, 16'h0000);

        // Reset clears hold; aborted commit; back-to-back; PxL without PxH
        do_reset();
        acc(1, 0, 4'd10, 0, 1, 8'h7F);
        chk("p1h_no_commit", p1, 16'h0001);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("p1_after_rst", p1, 16'h0001);
        acc(1, 0, 4'd9, 0, 1, 8'h00);
        chk("p1_hold_cleared", p1, 16'h0000);

        do_reset();
        acc(1, 0, 4'd10, 0, 1, 8'h7F);
        @(negedge clk);
        cs_io = 1'b1; cs_ff = 1'b0; addr = 4'd9; rd_stb = 1'b0; wr_stb = 1'b1; din = 8'h99;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cs_io = 1'b0; wr_stb = 1'b0;
        chk("p1_abort", p1, 16'h0001);
        acc(1, 0, 4'd10, 0, 1, 8'hAB);
        acc(1, 0, 4'd9,  0, 1, 8'hCD);
        chk("p1_b2b", p1, 16'hABCD);
        acc(1, 0, 4'd7,  0, 1, 8'h56);
        chk("p0_lo_only", p0, 16'h0056);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
